// File: rtl/onehot_req_encoder.sv
// onehot_req_encoder: latches request lines into a pending register and
// presents one pending request at a time as a binary index on a valid/ready
// handshake. MODE=1 picks the lowest pending index; MODE=0 accepts only a
// one-hot pending set and pulses err (discarding the stale set) otherwise.
module onehot_req_encoder #(
    parameter int N    = 8,
    parameter int MODE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err,
    output logic [N-1:0]         pending
);
    localparam int W = $clog2(N);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    logic [0:0]   state;
    logic [W-1:0] low_idx;
    logic         multi_hot;
    logic         handshake;
    logic [N-1:0] clr_mask;

    // out_valid is a decode of the registered state, so it is glitch-free
    assign out_valid = (state == PRESENT);
    assign handshake = out_valid && out_ready;

    // x & (x-1) is non-zero exactly when two or more bits of x are set
    assign multi_hot = |(pending & (pending - N'(1)));

    // Lowest set bit of the registered pending value; scanning downwards lets
    // the last (lowest) hit win. Only indices 0..N-1 are ever produced.
    always_comb begin
        low_idx = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (pending[i-1]) begin
                low_idx = W'(i - 1);
            end
        end
    end

    // One-hot of the presented index, only on the accepting cycle
    always_comb begin
        clr_mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            clr_mask[i] = handshake && (out_idx == W'(i));
        end
    end

    // Pending accumulation (set wins over clear) and IDLE/PRESENT control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            out_idx <= '0;
            err     <= 1'b0;
            pending <= '0;
        end else begin
            err     <= 1'b0;
            pending <= (pending & ~clr_mask) | in;
            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        if (MODE == 0 && multi_hot) begin
                            // strict mode: drop the ambiguous set, keep only new requests
                            err     <= 1'b1;
                            pending <= in;
                        end else begin
                            out_idx <= low_idx;
                            state   <= PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/onehot_req_encoder.md
# onehot_req_encoder

Parametrised, registered successor to the team's 8-to-3 one-hot encoder. It latches N request lines into a pending register and encodes one pending request at a time into a binary index. Each index is presented on a valid/ready handshake, and its pending bit clears when the index is accepted. Two modes are supported: strict one-hot, which flags any multi-hot pending set as an error, and priority, where the lowest index wins. The block sits between raw request/event lines and a downstream consumer such as an interrupt or channel-select controller.

## Interface
- N, default 8: number of request inputs. Legal range 2..256; N need not be a power of two.
- MODE, default 1: 0 = strict one-hot; 1 = priority (lowest index wins).
- W (localparam), $clog2(N): width of the encoded index. N=8 gives 3.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  N  request lines, sampled every cycle. Level-sensitive: any 1 is ORed into the pending register.
- out_idx  output  W  encoded index of the request being presented.
- out_valid  output  1  out_idx is valid and held stable until accepted.
- out_ready  input  1  consumer accepts out_idx when out_valid && out_ready.
- err  output  1  one-cycle pulse in MODE=0 when the pending set is not one-hot.
- pending  output  N  current pending register, for debug and status.

## Operation
- Reset values: pending=0, out_idx=0, out_valid=0, err=0, FSM=IDLE. Reset asserted mid-handshake discards everything; no index is re-presented after reset.
- Pending update each cycle: pending_next = (pending & ~clr_mask) | in.
  - clr_mask is the one-hot of out_idx on a handshake cycle, and 0 otherwise.
  - Set wins over clear: if in[out_idx]=1 on the handshake cycle, that bit stays pending and is presented again later.
- FSM states: IDLE and PRESENT.
- IDLE, pending==0: stay in IDLE, out_valid=0.
- IDLE, MODE=1, pending!=0:
  - load out_idx with the lowest set bit index of pending.
  - set out_valid=1 and go to PRESENT.
- IDLE, MODE=0, pending is exactly one-hot: load out_idx with its index, set out_valid=1, go to PRESENT.
- IDLE, MODE=0, pending has two or more bits set:
  - pulse err=1 for one cycle.
  - clear all bits of pending except those asserted on in this cycle.
  - stay in IDLE; no index is presented.
- PRESENT:
  - out_idx and out_valid hold while out_ready=0; the consumer may stall indefinitely.
  - New requests keep accumulating in pending while stalled. In MODE=0 they do not raise err until the FSM is back in IDLE.
  - On handshake: clear pending[out_idx], drop out_valid, return to IDLE.
- Encoding arithmetic is unsigned and zero-extended. For non-power-of-two N, out_idx never exceeds N-1.
- The encoder evaluates only the registered pending value, never the raw in.

## Timing
- Request latency: in[k] high in cycle t gives pending[k]=1 after edge t+1, and out_valid=1 with out_idx=k after edge t+2. The minimum is 2 cycles.
- Handshake in cycle h: out_valid is 0 after edge h+1. The next index, if any is pending, is presented after edge h+2.
- Peak throughput is one index per 2 cycles.
- err is asserted for exactly one cycle, registered, one edge after IDLE evaluates a multi-hot pending set.
- out_idx changes only on the IDLE→PRESENT transition.
- out_valid never drops without a handshake, except on reset.
- Asynchronous reset takes effect immediately, regardless of clk. Release is synchronous to the next clk edge.

## Test plan
- Reset: rst=1 mid-PRESENT with out_idx=5 → all outputs go to 0 immediately. After release with in=0, out_valid stays 0 for 10 cycles.
- Single request, N=8, MODE=1: in=8'b0001_0000 for one cycle, out_ready=1 → out_valid rises 2 cycles later with out_idx=3'd4. It drops the next cycle, and pending returns to 0.
- Priority and stall, MODE=1: in=8'b1010_0100 pulsed, out_ready=0 for 5 cycles → out_idx=2 held stable. After ready, the indices presented are 5 then 7, each 2 cycles apart, and pending ends at 0.
- Strict error, MODE=0: in=8'b0000_0110 pulsed → err pulses for exactly 1 cycle, out_valid is never 1, pending returns to 0. A following in=8'b1000_0000 yields out_idx=7.
- Set-wins-clear: hold in[3]=1 continuously with out_ready=1 → index 3 is re-presented every 2 cycles, and pending[3] never reads 0.
- Non-power-of-two, N=5, W=3: in=5'b1_0000 → out_idx=3'd4. A sweep of all single-bit inputs produces indices 0..4 only.
